uart_baud_ctrl: RTL and testbench
=================================

Name: uart_baud_ctrl

Overview:
Runtime-configurable baud tick controller for the APB UART. It holds the active bit and 16x-oversample divisors and accepts new divisors from the register block through a shadow register. A new divisor takes effect only at a bit boundary, so a rate change never produces a runt bit. It also provides enable gating and a phase-restart input, so the RX path can align the tick phase to a detected start-bit edge. Its outputs baud_en and baud_en_16x feed the TX and RX engines.

Parameters:
CNT_W, 16, width of the divisor registers and the counters.
DEF_DIV, 433, reset value of the bit divisor (50 MHz / 115200 - 1).
DEF_DIV_OS, 26, reset value of the oversample divisor (50 MHz / (115200*16) - 1).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  level; 1 = ticks run, 0 = counters held at 0 and no ticks.
cfg_wr  input  1  one-cycle strobe; loads cfg_div and cfg_div_os into the shadow register.
cfg_div  input  CNT_W  requested bit divisor (period minus 1).
cfg_div_os  input  CNT_W  requested oversample divisor (period minus 1).
phase_rst  input  1  one-cycle strobe; restarts both counters.
baud_en  output  1  bit tick.
baud_en_16x  output  1  oversample tick.
cfg_pending  output  1  shadow loaded but not yet applied.
cfg_ack  output  1  one-cycle pulse in the cycle after the shadow is applied.
div_act  output  CNT_W  readback of the active bit divisor.
div_os_act  output  CNT_W  readback of the active oversample divisor.

Behaviour:
- Reset values:
  - div_act = DEF_DIV, div_os_act = DEF_DIV_OS.
  - Counters = 0, shadow = 0.
  - baud_en, baud_en_16x, cfg_pending and cfg_ack = 0.
  - State = IDLE.
- States:
  - IDLE: enable = 0.
  - RUN: enable = 1, no write pending.
  - PEND: enable = 1, shadow waiting to be applied.
- Transitions:
  - IDLE to RUN when enable is sampled high.
  - RUN to PEND on cfg_wr.
  - PEND to RUN at the apply point.
  - Any state to IDLE when enable is sampled low.
- Counters:
  - cnt and cnt_os count up only in RUN and PEND.
  - Each counter wraps to 0 when it equals its active divisor.
  - The first RUN cycle has cnt = 0.
  - Period = divisor + 1 cycles; divisor 0 gives a tick every cycle, which is legal.
- Ticks:
  - baud_en = (state != IDLE) and (cnt == div_act).
  - baud_en_16x = (state != IDLE) and (cnt_os == div_os_act).
  - Both are combinational from registers, with no extra latency.
- Apply point in PEND: the cycle in which baud_en = 1.
  - On the following edge, div_act and div_os_act take the shadow values.
  - Both counters go to 0.
  - cfg_pending clears and cfg_ack pulses for 1 cycle.
- cfg_wr in IDLE: applied on the next edge (divisors loaded, cfg_ack pulses, no pending). The state stays IDLE unless enable is also high, in which case it goes to RUN.
- cfg_wr while in PEND: the shadow is overwritten (last write wins). Only one cfg_ack is issued, for the final value.
- cfg_wr in the same cycle as the apply point: the old shadow is applied and acked, then the new write becomes pending. The state stays PEND.
- phase_rst (RUN or PEND): both counters go to 0 on the next edge, and no tick is issued that edge. A pending update stays pending.
- phase_rst in the same cycle as the apply point: the update applies and the counters reset; the result is the same as apply alone.
- phase_rst in IDLE: ignored.
- enable low mid-operation: counters go to 0 and ticks stop on the next edge.
  - A pending shadow is applied immediately on that edge and cfg_ack pulses.
- Counter width: CNT_W bits, unsigned compare. No divisor range checking in this block.
- Async reset mid-operation: all state returns to reset values immediately.

Decomposition:
- Shared package uart_pkg:
  - CNT_W.
  - DEF_DIV and DEF_DIV_OS (derived from the clock and baud constants).
  - State encoding localparams IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2.
- One sub-module, uart_tick_cnt, instantiated twice (bit counter and oversample counter).
  - Inputs: run, clr, div.
  - Output: tick.
- The state machine and the shadow/apply logic stay in the top module.

Test Plan:
1. Reset, then enable = 1 with defaults -> baud_en pulses every 434 cycles, first pulse in RUN cycle 434; baud_en_16x pulses every 27 cycles.
2. In RUN, cfg_wr with div = 9, div_os = 0 at cnt = 100 -> cfg_pending = 1 until the next baud_en. The old 434-cycle period completes, then cfg_ack pulses once, after which baud_en has a 10-cycle period and baud_en_16x is high every cycle.
3. Two cfg_wr while in PEND (div = 5, then div = 7) -> a single cfg_ack and div_act = 7. Also: cfg_wr in the same cycle as the apply point -> two acks in sequence.
4. phase_rst at cnt = 200, div = 433 -> next baud_en arrives 434 cycles after the strobe; the pending flag is unchanged.
5. cfg_wr with div = 3 while enable = 0 -> cfg_ack next cycle, div_act = 3, no ticks. Then enable = 1 -> first baud_en in RUN cycle 4.
6. enable dropped while in PEND, and rst_n asserted mid-count -> the shadow is applied with an ack and ticks stop. After reset: outputs 0 and div_act = 433.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: counter width, default divisors for 115200 baud at 50 MHz, FSM encoding.
package uart_pkg;

  localparam int CNT_W   = 16;
  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 115_200;
  localparam int OS_RATE = 16;

  // Divisors are stored as period minus one.
  localparam int DEF_DIV    = CLK_HZ / BAUD - 1;
  localparam int DEF_DIV_OS = CLK_HZ / (BAUD * OS_RATE) - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

endpackage

// File: rtl/uart_tick_cnt.sv
// Free-running divisor counter: wraps at div, tick is combinational from the count (no added latency).
// No backpressure; clr or !run force the count to 0 on the next edge.
module uart_tick_cnt #(
  parameter int CNT_W = uart_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_top;

  assign at_top = (cnt == div);
  assign tick   = run && at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !run || at_top) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud tick controller with shadowed divisors applied only on a bit boundary; ticks have zero latency.
// No backpressure; cfg_wr is always accepted, last write wins while an update is pending.
module uart_baud_ctrl #(
  parameter int CNT_W      = uart_pkg::CNT_W,
  parameter int DEF_DIV    = uart_pkg::DEF_DIV,
  parameter int DEF_DIV_OS = uart_pkg::DEF_DIV_OS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_div_os,
  input  logic             phase_rst,
  output logic             baud_en,
  output logic             baud_en_16x,
  output logic             cfg_pending,
  output logic             cfg_ack,
  output logic [CNT_W-1:0] div_act,
  output logic [CNT_W-1:0] div_os_act
);

  import uart_pkg::*;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] shadow_div;
  logic [CNT_W-1:0] shadow_div_os;
  logic             run;
  logic             apply_direct;
  logic             apply_shadow;
  logic             cnt_clr;

  assign run         = (state != IDLE);
  assign cfg_pending = (state == PEND);

  // A write seen while idle (or while dropping to idle) bypasses the shadow; there is no bit to protect.
  assign apply_direct = cfg_wr && ((state == IDLE) || !enable);
  assign apply_shadow = (state == PEND) && (baud_en || !enable) && !apply_direct;
  assign cnt_clr      = apply_direct || apply_shadow || phase_rst || !enable;

  uart_tick_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (cnt_clr),
    .div   (div_act),
    .tick  (baud_en)
  );

  uart_tick_cnt #(.CNT_W(CNT_W)) u_os_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (cnt_clr),
    .div   (div_os_act),
    .tick  (baud_en_16x)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (cfg_wr) state_nxt = PEND;
      PEND:    if (baud_en && !cfg_wr) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shadow_div    <= '0;
      shadow_div_os <= '0;
      div_act       <= CNT_W'(DEF_DIV);
      div_os_act    <= CNT_W'(DEF_DIV_OS);
      cfg_ack       <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_ack <= apply_direct || apply_shadow;
      if (cfg_wr) begin
        shadow_div    <= cfg_div;
        shadow_div_os <= cfg_div_os;
      end
      // Shadow is applied before the same-cycle write overwrites it.
      if (apply_direct) begin
        div_act    <= cfg_div;
        div_os_act <= cfg_div_os;
      end else if (apply_shadow) begin
        div_act    <= shadow_div;
        div_os_act <= shadow_div_os;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: divisor table plus hand-built apply/phase/enable/reset sequences.
module tb_uart_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cfg_wr;
  logic [15:0] cfg_div;
  logic [15:0] cfg_div_os;
  logic        phase_rst;
  logic        baud_en;
  logic        baud_en_16x;
  logic        cfg_pending;
  logic        cfg_ack;
  logic [15:0] div_act;
  logic [15:0] div_os_act;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] div;
    logic [15:0] div_os;
    int          first;
    int          first_os;
  } vec_t;

  vec_t vecs [5];

  uart_baud_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_wr      (cfg_wr),
    .cfg_div     (cfg_div),
    .cfg_div_os  (cfg_div_os),
    .phase_rst   (phase_rst),
    .baud_en     (baud_en),
    .baud_en_16x (baud_en_16x),
    .cfg_pending (cfg_pending),
    .cfg_ack     (cfg_ack),
    .div_act     (div_act),
    .div_os_act  (div_os_act)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_baud(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      step();
      if (baud_en === 1'b1) n = i;
    end
  endtask

  task automatic measure(input int max, output int b1, output int b2, output int o1, output int o2);
    b1 = -1; b2 = -1; o1 = -1; o2 = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (baud_en === 1'b1) begin
        if (b1 < 0) b1 = i;
        else if (b2 < 0) b2 = i;
      end
      if (baud_en_16x === 1'b1) begin
        if (o1 < 0) o1 = i;
        else if (o2 < 0) o2 = i;
      end
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    cfg_wr     = 1'b0;
    cfg_div    = '0;
    cfg_div_os = '0;
    phase_rst  = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int b1, b2, o1, o2, n, cnt, mx;

    vecs[0] = '{div: 16'd3,   div_os: 16'd0,  first: 4,   first_os: 1};
    vecs[1] = '{div: 16'd9,   div_os: 16'd2,  first: 10,  first_os: 3};
    vecs[2] = '{div: 16'd0,   div_os: 16'd0,  first: 1,   first_os: 1};
    vecs[3] = '{div: 16'd1,   div_os: 16'd15, first: 2,   first_os: 16};
    vecs[4] = '{div: 16'd433, div_os: 16'd26, first: 434, first_os: 27};

    // Reset state
    do_reset();
    check("rst baud_en", 32'(baud_en), 0);
    check("rst baud_en_16x", 32'(baud_en_16x), 0);
    check("rst cfg_pending", 32'(cfg_pending), 0);
    check("rst cfg_ack", 32'(cfg_ack), 0);
    check("rst div_act", 32'(div_act), 433);
    check("rst div_os_act", 32'(div_os_act), 26);

    // Default divisors
    enable = 1'b1;
    measure(900, b1, b2, o1, o2);
    check("def first baud", b1, 434);
    check("def baud period", b2 - b1, 434);
    check("def first os", o1, 27);
    check("def os period", o2 - o1, 27);

    // Divisor table, each loaded while idle
    foreach (vecs[i]) begin
      enable = 1'b0;
      step();
      cfg_wr     = 1'b1;
      cfg_div    = vecs[i].div;
      cfg_div_os = vecs[i].div_os;
      step();
      cfg_wr = 1'b0;
      check($sformatf("v%0d idle ack", i), 32'(cfg_ack), 1);
      check($sformatf("v%0d idle div_act", i), 32'(div_act), 32'(vecs[i].div));
      check($sformatf("v%0d idle no tick", i), 32'(baud_en), 0);
      enable = 1'b1;
      mx = 2 * ((vecs[i].first > vecs[i].first_os) ? vecs[i].first : vecs[i].first_os) + 2;
      measure(mx, b1, b2, o1, o2);
      check($sformatf("v%0d first baud", i), b1, vecs[i].first);
      check($sformatf("v%0d baud period", i), b2 - b1, vecs[i].first);
      check($sformatf("v%0d first os", i), o1, vecs[i].first_os);
      check($sformatf("v%0d os period", i), o2 - o1, vecs[i].first_os);
    end

    // Update in RUN at cnt=100 waits for the bit boundary
    do_reset();
    enable = 1'b1;
    step();
    repeat (100) step();
    cfg_wr = 1'b1; cfg_div = 16'd9; cfg_div_os = 16'd0;
    step();
    cfg_wr = 1'b0;
    check("t2 pending set", 32'(cfg_pending), 1);
    wait_baud(400, n);
    check("t2 old period completes", n, 332);
    check("t2 pending at apply", 32'(cfg_pending), 1);
    check("t2 no early ack", 32'(cfg_ack), 0);
    step();
    check("t2 ack", 32'(cfg_ack), 1);
    check("t2 pending clear", 32'(cfg_pending), 0);
    check("t2 div_act", 32'(div_act), 9);
    check("t2 div_os_act", 32'(div_os_act), 0);
    wait_baud(20, n);
    check("t2 first new baud", n, 9);
    cnt = 0;
    repeat (10) begin
      step();
      if (baud_en_16x !== 1'b1) cnt++;
    end
    check("t2 os every cycle", cnt, 0);
    check("t2 baud period 10", 32'(baud_en), 1);

    // Two writes while pending: one ack, last value wins
    cfg_wr = 1'b1; cfg_div = 16'd5;
    step();
    cfg_div = 16'd7;
    step();
    cfg_wr = 1'b0;
    cnt = 0;
    repeat (30) begin
      step();
      if (cfg_ack === 1'b1) cnt++;
    end
    check("t3 single ack", cnt, 1);
    check("t3 last write wins", 32'(div_act), 7);

    // Write in the apply cycle: old shadow acked, new one left pending
    wait_baud(20, n);
    cfg_wr = 1'b1; cfg_div = 16'd4; cfg_div_os = 16'd1;
    step();
    cfg_wr = 1'b0;
    wait_baud(20, n);
    check("t3 apply wait", n, 7);
    cfg_wr = 1'b1; cfg_div = 16'd6; cfg_div_os = 16'd2;
    step();
    cfg_wr = 1'b0;
    check("t3 ack1", 32'(cfg_ack), 1);
    check("t3 ack1 div", 32'(div_act), 4);
    check("t3 still pending", 32'(cfg_pending), 1);
    wait_baud(20, n);
    check("t3 period after apply", n, 4);
    step();
    check("t3 ack2", 32'(cfg_ack), 1);
    check("t3 ack2 div", 32'(div_act), 6);
    check("t3 pending clear", 32'(cfg_pending), 0);

    // phase_rst at cnt=200 with an update pending
    do_reset();
    enable = 1'b1;
    step();
    repeat (150) step();
    cfg_wr = 1'b1; cfg_div = 16'd50; cfg_div_os = 16'd3;
    step();
    cfg_wr = 1'b0;
    repeat (49) step();
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    check("t4 pending kept", 32'(cfg_pending), 1);
    wait_baud(500, n);
    check("t4 baud after phase_rst", n + 1, 434);
    check("t4 pending at tick", 32'(cfg_pending), 1);
    step();
    check("t4 ack", 32'(cfg_ack), 1);
    check("t4 div_act", 32'(div_act), 50);

    // enable dropped while pending
    cfg_wr = 1'b1; cfg_div = 16'd20; cfg_div_os = 16'd1;
    step();
    cfg_wr = 1'b0;
    repeat (5) step();
    check("t6 pending", 32'(cfg_pending), 1);
    enable = 1'b0;
    step();
    check("t6 ack on disable", 32'(cfg_ack), 1);
    check("t6 div_act", 32'(div_act), 20);
    check("t6 div_os_act", 32'(div_os_act), 1);
    check("t6 pending clear", 32'(cfg_pending), 0);
    cnt = 0;
    repeat (30) begin
      step();
      if (baud_en === 1'b1 || baud_en_16x === 1'b1) cnt++;
    end
    check("t6 no ticks idle", cnt, 0);

    // Async reset mid-count
    enable = 1'b1;
    repeat (12) step();
    check("t6 os tick before rst", 32'(baud_en_16x), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async baud_en", 32'(baud_en), 0);
    check("t6 async baud_en_16x", 32'(baud_en_16x), 0);
    check("t6 async pending", 32'(cfg_pending), 0);
    check("t6 async div_act", 32'(div_act), 433);
    check("t6 async div_os_act", 32'(div_os_act), 26);
    step();
    rst_n = 1'b1;
    enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
